// File: rtl/spongent_absorb_feeder.sv
// spongent_absorb_feeder: byte-stream front end for the Spongent Absorb stage.
// Packs message bytes into RATE_BYTES-wide blocks, applies 0x80/zero padding,
// XORs each block into the running sponge state for the Absorb permutation,
// and presents the final absorbed state to the squeeze stage.
// Optional feature: define SPONGENT_FEEDER_BITCNT_EN to add the msg_bits
// output, which counts accepted message bits.
module spongent_absorb_feeder #(
    parameter int STATE_W    = 264,
    parameter int RATE_BYTES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         msg_data,
    input  logic               msg_valid,
    input  logic               msg_last,
    input  logic               msg_empty,
    output logic               msg_ready,
    output logic [STATE_W-1:0] perm_state_in,
    output logic               perm_en,
    input  logic [STATE_W-1:0] perm_state_out,
    input  logic               perm_rdy,
    output logic [STATE_W-1:0] abs_state,
    output logic               abs_valid,
    input  logic               abs_ready
`ifdef SPONGENT_FEEDER_BITCNT_EN
    ,
    output logic [31:0]        msg_bits
`endif
);

    localparam int RATE_W = RATE_BYTES * 8;
    localparam int IDX_W  = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_BYTES - 1);
    localparam logic [RATE_W-1:0] PAD_BLOCK = RATE_W'(8'h80);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PERM,
        S_PAD,
        S_DONE
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_reg_q, state_reg_d;
    logic [RATE_W-1:0]  block_buf_q, block_buf_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic               final_flag_q, final_flag_d;
    logic               pad_pend_q, pad_pend_d;
`ifdef SPONGENT_FEEDER_BITCNT_EN
    logic [31:0]        bit_cnt_q, bit_cnt_d;
`endif

    // Register all feeder state; reset aborts any message in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= S_IDLE;
            state_reg_q  <= '0;
            block_buf_q  <= '0;
            byte_idx_q   <= '0;
            final_flag_q <= 1'b0;
            pad_pend_q   <= 1'b0;
`ifdef SPONGENT_FEEDER_BITCNT_EN
            bit_cnt_q    <= '0;
`endif
        end else begin
            fsm_q        <= fsm_d;
            state_reg_q  <= state_reg_d;
            block_buf_q  <= block_buf_d;
            byte_idx_q   <= byte_idx_d;
            final_flag_q <= final_flag_d;
            pad_pend_q   <= pad_pend_d;
`ifdef SPONGENT_FEEDER_BITCNT_EN
            bit_cnt_q    <= bit_cnt_d;
`endif
        end
    end

    // Next-state logic: byte packing, padding decisions and permutation handoff.
    always_comb begin
        fsm_d        = fsm_q;
        state_reg_d  = state_reg_q;
        block_buf_d  = block_buf_q;
        byte_idx_d   = byte_idx_q;
        final_flag_d = final_flag_q;
        pad_pend_d   = pad_pend_q;
`ifdef SPONGENT_FEEDER_BITCNT_EN
        bit_cnt_d    = bit_cnt_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                state_reg_d  = '0;
                block_buf_d  = '0;
                byte_idx_d   = '0;
                final_flag_d = 1'b0;
                pad_pend_d   = 1'b0;
`ifdef SPONGENT_FEEDER_BITCNT_EN
                bit_cnt_d    = '0;
`endif
                fsm_d        = S_FILL;
            end
            S_FILL: begin
                if (msg_valid) begin
                    if (msg_last && msg_empty && (byte_idx_q == '0)) begin
                        block_buf_d  = PAD_BLOCK;
                        final_flag_d = 1'b1;
                        byte_idx_d   = '0;
                        fsm_d        = S_PERM;
                    end else begin
                        for (int k = 0; k < RATE_BYTES; k++) begin
                            if (byte_idx_q == IDX_W'(k)) begin
                                block_buf_d[8*k +: 8] = msg_data;
                            end
                        end
`ifdef SPONGENT_FEEDER_BITCNT_EN
                        bit_cnt_d = bit_cnt_q + 32'd8;
`endif
                        if (msg_last) begin
                            byte_idx_d = '0;
                            fsm_d      = S_PERM;
                            if (byte_idx_q == LAST_IDX) begin
                                pad_pend_d = 1'b1;
                            end else begin
                                for (int k = 1; k < RATE_BYTES; k++) begin
                                    if (byte_idx_q == IDX_W'(k - 1)) begin
                                        block_buf_d[8*k +: 8] = 8'h80;
                                    end
                                end
                                final_flag_d = 1'b1;
                            end
                        end else if (byte_idx_q == LAST_IDX) begin
                            byte_idx_d   = '0;
                            final_flag_d = 1'b0;
                            fsm_d        = S_PERM;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
            end
            S_PERM: begin
                if (perm_rdy) begin
                    state_reg_d = perm_state_out;
                    block_buf_d = '0;
                    if (final_flag_q) begin
                        fsm_d = S_DONE;
                    end else if (pad_pend_q) begin
                        fsm_d = S_PAD;
                    end else begin
                        fsm_d = S_FILL;
                    end
                end
            end
            S_PAD: begin
                block_buf_d  = PAD_BLOCK;
                pad_pend_d   = 1'b0;
                final_flag_d = 1'b1;
                fsm_d        = S_PERM;
            end
            S_DONE: begin
                if (abs_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded straight from registered state so they drop the moment reset asserts.
    always_comb begin
        msg_ready     = (fsm_q == S_FILL);
        perm_en       = (fsm_q == S_PERM);
        abs_valid     = (fsm_q == S_DONE);
        abs_state     = state_reg_q;
        perm_state_in = state_reg_q ^ STATE_W'(block_buf_q);
`ifdef SPONGENT_FEEDER_BITCNT_EN
        msg_bits      = bit_cnt_q;
`endif
    end

endmodule
